// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED fade driver: channel state encoding,
// brightness width and active-low LED drive levels.
package led_fade_pkg;

  localparam int LVL_W = 4;

  typedef enum logic [3:0] {
    ST_OFF  = 4'b0001,
    ST_RISE = 4'b0010,
    ST_FULL = 4'b0100,
    ST_FALL = 4'b1000
  } fade_state_e;

  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness FSM stepped by the shared fade tick, plus the
// registered PWM compare against the shared phase counter.
//
// state | meaning
// OFF   | dark, b=0, waiting for the target to turn on
// RISE  | ramping up one level per step tick (INSTANT_ON=0 only)
// FULL  | held at LVL_MAX while the target stays on
// FALL  | fading down one level per step tick, back to OFF at 0
module led_fade_channel import led_fade_pkg::*; #(
  parameter logic [LVL_W-1:0] LVL_MAX    = 4'd15,
  parameter bit               INSTANT_ON = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             target_i,
  input  logic             step_tick_i,
  input  logic [LVL_W-1:0] phase_i,
  output logic [LVL_W-1:0] b_o,
  output logic             led_o
);

  fade_state_e      state_q;
  logic [LVL_W-1:0] b_q;
  logic             led_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_OFF;
      b_q     <= '0;
      led_q   <= LED_OFF;
    end else if (!en_i) begin
      state_q <= ST_OFF;
      b_q     <= '0;
      led_q   <= LED_OFF;
    end else begin
      led_q <= (phase_i < b_q) ? LED_ON : LED_OFF;
      // A target change always takes priority over a coincident step tick.
      case (state_q)
        ST_OFF: begin
          if (target_i) begin
            if (INSTANT_ON) begin
              b_q     <= LVL_MAX;
              state_q <= ST_FULL;
            end else begin
              state_q <= ST_RISE;
            end
          end
        end
        ST_RISE: begin
          if (!target_i) begin
            state_q <= ST_FALL;
          end else if (step_tick_i) begin
            if (b_q >= LVL_MAX - 4'd1) begin
              b_q     <= LVL_MAX;
              state_q <= ST_FULL;
            end else begin
              b_q <= b_q + 4'd1;
            end
          end
        end
        ST_FULL: begin
          if (!target_i) state_q <= ST_FALL;
        end
        ST_FALL: begin
          if (target_i) begin
            if (INSTANT_ON) begin
              b_q     <= LVL_MAX;
              state_q <= ST_FULL;
            end else begin
              state_q <= ST_RISE;
            end
          end else if (step_tick_i) begin
            if (b_q <= 4'd1) begin
              b_q     <= '0;
              state_q <= ST_OFF;
            end else begin
              b_q <= b_q - 4'd1;
            end
          end
        end
        default: begin
          state_q <= ST_OFF;
          b_q     <= '0;
        end
      endcase
    end
  end

  assign b_o   = b_q;
  assign led_o = led_q;

endmodule

// File: rtl/led_fade_driver.sv
// Drives four active-low board LEDs from the sequencer pattern with per-LED
// PWM brightness, instant (or ramped) turn-on and a fading comet tail.
module led_fade_driver import led_fade_pkg::*; #(
  parameter logic [31:0]      SLOT_MAX   = 32'd77,
  parameter logic [LVL_W-1:0] LVL_MAX    = 4'd15,
  parameter logic [31:0]      STEP_MAX   = 32'd3_906_249,
  parameter bit               INSTANT_ON = 1'b1
) (
  input  logic       clk_125mhz,
  input  logic       rst,
  input  logic [3:0] led_in,
  input  logic       en,
  output logic [3:0] led_out
);

  logic [3:0]       led_in_q;
  logic [31:0]      slot_q;
  logic [31:0]      step_q;
  logic [LVL_W-1:0] phase_q;
  logic             step_tick;
  // Per-channel brightness is left as a probe point; nothing at this level uses it.
  logic [LVL_W-1:0] lvl_unused [4];

  always_ff @(posedge clk_125mhz or negedge rst) begin
    if (!rst) begin
      led_in_q <= 4'b1111;
      slot_q   <= '0;
      phase_q  <= '0;
      step_q   <= '0;
    end else begin
      led_in_q <= led_in;
      if (!en) begin
        slot_q  <= '0;
        phase_q <= '0;
        step_q  <= '0;
      end else begin
        if (slot_q == SLOT_MAX) begin
          slot_q  <= '0;
          phase_q <= (phase_q == LVL_MAX - 4'd1) ? '0 : phase_q + 4'd1;
        end else begin
          slot_q <= slot_q + 32'd1;
        end
        step_q <= (step_q == STEP_MAX) ? '0 : step_q + 32'd1;
      end
    end
  end

  assign step_tick = en && (step_q == STEP_MAX);

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    led_fade_channel #(
      .LVL_MAX    (LVL_MAX),
      .INSTANT_ON (INSTANT_ON)
    ) u_ch (
      .clk_i       (clk_125mhz),
      .rst_ni      (rst),
      .en_i        (en),
      .target_i    (led_in_q[gi] == LED_ON),
      .step_tick_i (step_tick),
      .phase_i     (phase_q),
      .b_o         (lvl_unused[gi]),
      .led_o       (led_out[gi])
    );
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver: one instance with instant turn-on and
// one with ramped turn-on, short PWM slot and step periods.
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] led_in;
  logic [3:0] led_in_r;
  logic [3:0] led_out;
  logic [3:0] led_out_r;

  always #4 clk = ~clk;

  led_fade_driver #(
    .SLOT_MAX(32'd1), .LVL_MAX(4'd15), .STEP_MAX(32'd99), .INSTANT_ON(1'b1)
  ) dut (
    .clk_125mhz(clk), .rst(rst), .led_in(led_in), .en(en), .led_out(led_out)
  );

  led_fade_driver #(
    .SLOT_MAX(32'd1), .LVL_MAX(4'd15), .STEP_MAX(32'd99), .INSTANT_ON(1'b0)
  ) dut_r (
    .clk_125mhz(clk), .rst(rst), .led_in(led_in_r), .en(en), .led_out(led_out_r)
  );

  // kind 0: whole led_out vector, 1: single bit, 2: lit cycles in last 30 samples
  typedef struct {
    int    at;
    string nm;
    int    kind;
    int    dsel;
    int    idx;
    int    ev;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [29:0] hz [2][4] = '{default: '0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int ev);
    checks++;
    if (act != ev) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, ev, cyc);
    end
  endfunction

  function automatic int observe(int kind, int dsel, int idx);
    logic [3:0] lo;
    lo = (dsel == 0) ? led_out : led_out_r;
    case (kind)
      0:       return int'({28'd0, lo});
      1:       return int'({31'd0, lo[idx]});
      default: return $countones(hz[dsel][idx]);
    endcase
  endfunction

  function automatic void exp_at(int k, string nm, int kind, int dsel, int idx, int ev);
    exp_t e;
    e.at = t0 + k; e.nm = nm; e.kind = kind; e.dsel = dsel; e.idx = idx; e.ev = ev;
    sb_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        hz[d][i] = {hz[d][i][28:0], (d == 0) ? ~led_out[i] : ~led_out_r[i]};
    for (int j = sb_q.size() - 1; j >= 0; j--) begin
      e = sb_q[j];
      if (e.at == cyc) begin
        chk(e.nm, observe(e.kind, e.dsel, e.idx), e.ev);
        sb_q.delete(j);
      end else if (e.at < cyc) begin
        chk({e.nm, "_unobserved"}, 0, 1);
        sb_q.delete(j);
      end
    end
  end

  task automatic wait_k(int k);
    while (cyc - t0 < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst      = 1'b0;
    en       = 1'b1;
    led_in   = 4'($urandom);
    led_in_r = 4'($urandom);

    // reset held with random pattern
    for (int k = 2; k <= 4; k++) begin
      exp_at(k, "rst_hold", 0, 0, 0, 4'hF);
      exp_at(k, "rst_hold_r", 0, 1, 0, 4'hF);
    end
    for (int k = 1; k <= 5; k++) begin
      wait_k(k);
      led_in   = 4'($urandom);
      led_in_r = 4'($urandom);
    end
    led_in   = 4'hF;
    led_in_r = 4'hF;
    rst      = 1'b1;
    t0       = cyc;

    for (int k = 10; k <= 960; k += 50) begin
      exp_at(k, "idle", 0, 0, 0, 4'hF);
      exp_at(k, "idle_r", 0, 1, 0, 4'hF);
    end
    // instant on after edge 1005
    exp_at(1007, "on_lat2", 0, 0, 0, 4'hF);
    exp_at(1008, "on_lat3", 0, 0, 0, 4'hE);
    for (int j = 0; j < 10; j++) exp_at(1010 + 20 * j, "on_hold", 0, 0, 0, 4'hE);
    exp_at(1199, "full_duty", 2, 0, 0, 30);
    // fade from edge 1200: b=14-m during steps 1300+100m
    for (int m = 0; m <= 13; m++)
      exp_at(1399 + 100 * m, $sformatf("fade_duty_b%0d", 14 - m), 2, 0, 0, 2 * (14 - m));
    exp_at(2702, "fade_done", 0, 0, 0, 4'hF);
    exp_at(2750, "fade_done", 0, 0, 0, 4'hF);
    exp_at(2799, "fade_done_duty", 2, 0, 0, 0);
    exp_at(2802, "reon_lat2", 1, 0, 0, 1);
    exp_at(2803, "reon_lat3", 1, 0, 0, 0);
    // collision at step edge 3800 with b=7
    exp_at(3699, "pre_coll_b8", 2, 0, 0, 16);
    exp_at(3799, "pre_coll_b7", 2, 0, 0, 14);
    exp_at(3800, "coll_edge", 1, 0, 0, 1);
    exp_at(3801, "coll_full", 1, 0, 0, 0);
    exp_at(3830, "coll_full_duty", 2, 0, 0, 30);
    // water lamp
    exp_at(3952, "lamp1_lat2", 1, 0, 1, 1);
    exp_at(3953, "lamp1_lat3", 1, 0, 1, 0);
    exp_at(4352, "lamp2_lat2", 1, 0, 2, 1);
    exp_at(4353, "lamp2_lat3", 1, 0, 2, 0);
    exp_at(4752, "lamp3_lat2", 1, 0, 3, 1);
    exp_at(4753, "lamp3_lat3", 1, 0, 3, 0);
    exp_at(4749, "lamp_a_ch0", 2, 0, 0, 14);
    exp_at(4749, "lamp_a_ch1", 2, 0, 1, 22);
    exp_at(4749, "lamp_a_ch2", 2, 0, 2, 30);
    exp_at(5149, "tail_ch0_b3", 2, 0, 0, 6);
    exp_at(5149, "tail_ch1_b7", 2, 0, 1, 14);
    exp_at(5149, "tail_ch2_b11", 2, 0, 2, 22);
    exp_at(5149, "tail_ch3_b15", 2, 0, 3, 30);
    exp_at(5161, "en_off", 0, 0, 0, 4'hF);
    exp_at(5161, "en_off_r", 0, 1, 0, 4'hF);
    // ramped instance
    exp_at(1099, "ramp_b0", 2, 1, 0, 0);
    exp_at(1199, "ramp_b1", 2, 1, 0, 2);
    exp_at(2499, "ramp_b14", 2, 1, 0, 28);
    exp_at(2550, "ramp_full", 1, 1, 0, 0);
    exp_at(2599, "ramp_full_duty", 2, 1, 0, 30);
    exp_at(3499, "r_pre_coll_b7", 2, 1, 0, 14);
    exp_at(3599, "r_coll_keep_b7", 2, 1, 0, 14);
    exp_at(3699, "r_ramp_b8", 2, 1, 0, 16);
    exp_at(4199, "r_ramp_b13", 2, 1, 0, 26);
    exp_at(4299, "r_ramp_b14", 2, 1, 0, 28);
    exp_at(4330, "r_ramp_full", 2, 1, 0, 30);

    wait_k(1005); led_in = 4'hE; led_in_r = 4'hE;
    wait_k(1200); led_in = 4'hF;
    wait_k(2600); led_in_r = 4'hF;
    wait_k(2800); led_in = 4'hE;
    wait_k(2900); led_in = 4'hF;
    wait_k(3498); led_in_r = 4'hE;
    wait_k(3798); led_in = 4'hE;
    wait_k(3950); led_in = 4'hD;
    wait_k(4350); led_in = 4'hB;
    wait_k(4750); led_in = 4'h7;
    wait_k(5160); en = 1'b0;
    wait_k(5162); led_in = 4'hF; led_in_r = 4'hF;
    wait_k(5170); en = 1'b1;
    t0 = cyc;

    // resume after clear: counters restart from zero
    exp_at(5, "resume_idle", 0, 0, 0, 4'hF);
    for (int k = 5; k <= 200; k += 45) exp_at(k, "resume_idle_r", 0, 1, 0, 4'hF);
    for (int i = 1; i < 4; i++) exp_at(199, $sformatf("cleared_ch%0d", i), 2, 0, i, 0);
    exp_at(12, "resume_lat2", 1, 0, 0, 1);
    exp_at(13, "resume_lat3", 1, 0, 0, 0);
    exp_at(99, "resume_fall_b15", 2, 0, 0, 30);
    exp_at(199, "resume_fall_b14", 2, 0, 0, 28);
    exp_at(299, "pre_rst_on", 1, 0, 0, 0);

    wait_k(10);  led_in = 4'hE;
    wait_k(20);  led_in = 4'hF;
    wait_k(250); led_in = 4'hE;
    wait_k(300);
    chk("async_pre", int'({31'd0, led_out[0]}), 0);
    #1 rst = 1'b0;
    #1;
    chk("async_rst", int'({28'd0, led_out}), 4'hF);
    chk("async_rst_r", int'({28'd0, led_out_r}), 4'hF);

    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    t0  = cyc;
    exp_at(2, "post_rst_lat2", 0, 0, 0, 4'hF);
    exp_at(3, "post_rst_lat3", 0, 0, 0, 4'hE);
    wait_k(10);

    if (sb_q.size() != 0) chk("scoreboard_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
Downstream stage of the water-lamp sequencer. It consumes the sequencer's 4-bit active-low LED pattern and drives the board LEDs with per-LED PWM brightness. A lit LED comes on instantly, or ramps up when INSTANT_ON=0; a released LED fades out over about 470 ms, so the running light leaves a comet tail. Runs on the same 125 MHz clock as the sequencer, so no CDC is needed.

Parameters:
SLOT_MAX, 32'd77, PWM slot length minus 1 in clk cycles (78 cycles per slot).
LVL_MAX, 4'd15, maximum brightness and number of PWM slots per period (15 × 78 = 1170 cycles, about 107 kHz).
STEP_MAX, 32'd3_906_249, fade step interval minus 1 in cycles (31.25 ms; 15 steps ≈ 469 ms).
INSTANT_ON, 1'b1, 1 = rising edge jumps to full brightness; 0 = ramps up like the fall.

Ports:
clk_125mhz  input  1  system clock, 125 MHz
rst  input  1  asynchronous, active-low reset
led_in  input  4  active-low pattern from the sequencer (0 = LED requested on)
en  input  1  1 = normal operation; 0 = blank and clear all channels
led_out  output  4  active-low LED drive, registered

Behaviour:
- Reset (rst=0, async): led_out=4'b1111; all brightness=0; all channels in OFF; slot, phase and step counters=0; led_in_q=4'b1111.
- led_in_q: register of led_in, updated every cycle. Channel target is ON when led_in_q[i]=0.
- Slot counter:
  - counts 0..SLOT_MAX, then wraps.
  - phase advances when slot==SLOT_MAX, counting 0..LVL_MAX-1 and wrapping.
- Step counter: counts 0..STEP_MAX. step_tick=1 for the single cycle where step counter==STEP_MAX.
- Per-channel brightness b[i]: 4 bits, saturating in the range 0..LVL_MAX.
- Per-channel FSM, one-hot: OFF=4'b0001, RISE=4'b0010, FULL=4'b0100, FALL=4'b1000.
  - OFF: target ON → if INSTANT_ON, b=LVL_MAX and go to FULL; otherwise go to RISE. b stays 0.
  - RISE: on step_tick, b+1; when b reaches LVL_MAX, go to FULL. Target OFF → FALL, no b change that cycle.
  - FULL: target OFF → FALL. Target ON → stay.
  - FALL:
    - on step_tick, b-1; when b reaches 0, go to OFF.
    - target ON → INSTANT_ON ? (b=LVL_MAX, FULL) : RISE. The current level is kept for the ramp.
  - Target change and step_tick in the same cycle: the target decision wins and b is not stepped that cycle.
- Output: led_out[i] <= (en && phase < b[i]) ? 1'b0 : 1'b1, registered. b=LVL_MAX gives a constant 0; b=0 gives a constant 1.
- Latency with INSTANT_ON=1: led_in[i] falls at edge N; led_in_q at N+1; b=15 at N+2; led_out[i]=0 at N+3.
- en=0:
  - synchronous clear: all channels to OFF with b=0; counters to 0.
  - led_out=4'b1111 from the next edge.
  - Operation resumes the cycle after en returns to 1.
- led_in=4'b1111 (sequencer in reset or IDLE): all lit channels fade to OFF normally.
- Multiple bits low: channels are independent, with no restriction on how many are lit.
- Reset asserted mid-fade: immediate return to reset values, with no completion of the fade.

Decomposition:
- Shared package led_fade_pkg:
  - state encodings OFF/RISE/FULL/FALL
  - LVL_W=4
  - led active-low constants LED_ON=1'b0 and LED_OFF=1'b1
- Sub-module led_fade_channel, instantiated 4 times:
  - inputs: target, step_tick, phase, en
  - outputs: b and the registered led bit
  - contains the FSM and the compare
- Top level holds led_in_q, the slot/phase/step counters and the generate loop.

Test Plan (sim params SLOT_MAX=1, STEP_MAX=99, LVL_MAX=15 → 30-cycle period, 100-cycle step):
1. Reset: hold rst=0 with random led_in → led_out=4'b1111. Release, led_in=4'b1111 → led_out stays 1111 for 1000 cycles.
2. Instant on, INSTANT_ON=1: led_in 1111→1110 at edge N → led_out[0]=0 at N+3 and stays 0 continuously (b=15); other bits stay 1.
3. Fade out: after (2), led_in→1111 → b[0] decrements by 1 every 100 cycles. Measured duty of led_out[0]=0 over each 30-cycle period equals 2·b/30 (14/15 … 1/15). OFF after 1500 cycles; then constant 1.
4. Reversal and collision:
   - at b[0]=7 in FALL, drive led_in[0]=0 on the cycle of step_tick → b stays 7 that cycle, then jumps to 15 and FULL.
   - with INSTANT_ON=0, the ramp instead continues 7→15 over 800 cycles.
5. Water-lamp sequence: rotate a single 0 through 1110→1101→1011→0111 every 400 cycles → the newly lit LED is full at +3 cycles; the previous three show b=11, 7, 3 (comet tail), checked per channel.
6. en and reset mid-fade:
   - en=0 during a fade → led_out=1111 next edge; all b=0 and OFF.
   - rst=0 asynchronously mid-period → led_out=1111 immediately, without waiting for a clock edge.
